// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller and its storage.
package fifo_pkg;

    localparam int WIDTH_D    = 8;
    localparam int DEPTH_D    = 16;
    localparam int ADDR_W_D   = 4;
    localparam int FIFO_PTR_W = ADDR_W_D + 1;

    // Occupancy from wrap-bit pointers: difference taken modulo 2**ptr_w.
    function automatic int unsigned occupancy(input int unsigned wp,
                                              input int unsigned rp,
                                              input int unsigned ptr_w);
        return (wp - rp) & ((32'd1 << ptr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bus of the FIFO; almost flags exist only with SYNC_FIFO_ALMOST_FLAGS_EN.
interface sync_fifo_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    // Handshake: a push is taken on an edge where wr_en=1 and full=0; a pop is taken
    // where rd_en=1 and empty=0, and its word appears on rd_data with rd_valid=1 next cycle.
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/sync_fifo_ctrl_storage.sv
// Dual-port register array: write port A, registered read port B (rdata cleared on rst).
module fifo_storage #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and error logic of a single-clock FIFO; define SYNC_FIFO_ALMOST_FLAGS_EN
// to add registered almost_full/almost_empty outputs.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH  = WIDTH_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int ADDR_W = ADDR_W_D
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    , parameter int AF_TH = 12
    , parameter int AE_TH = 2
`endif
)(
    input  logic            clk,
    input  logic            rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic [PTR_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Status comes from registered pointers only, so a same-edge push never feeds a pop.
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = PTR_W'(occupancy(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_W));
    assign w_push  = bus.wr_en && !w_full;
    assign w_pop   = bus.rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_valid <= w_pop;
            if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
            if (bus.rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    fifo_storage #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (w_push),
        .waddr (r_wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .re    (w_pop),
        .raddr (r_rd_ptr[ADDR_W-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    logic             r_almost_full;
    logic             r_almost_empty;
    logic [PTR_W-1:0] w_count_nxt;

    // Registered from the post-edge occupancy so they track count with no extra lag.
    assign w_count_nxt = w_count + PTR_W'(w_push) - PTR_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= PTR_W'(AF_TH));
            r_almost_empty <= (w_count_nxt <= PTR_W'(AE_TH));
        end
    end

    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
`endif

endmodule
